// File: rtl/serial_subtractor32.sv
// serial_subtractor32 -- multi-cycle subtractor, D = A - B - Bin.
//
// One CHUNK-bit slice is subtracted per clock, least significant first,
// with the borrow held in a register between slices. A full result takes
// N = BITS/CHUNK cycles of BUSY after the operands are accepted.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   A/B/Bin valid           in_ready   block accepts operands
//   A, B, Bin  minuend, subtrahend, borrow-in
//   out_valid  D/Bout valid            out_ready  consumer takes result
//   D          difference mod 2^BITS   Bout       1 iff A < B + Bin (unsigned)
//   V          signed overflow (only with SUB_OVERFLOW_FLAG_EN defined)
//
// Optional feature macro: SUB_OVERFLOW_FLAG_EN (adds output V).

// One slice of the borrow chain: {bout, d} = a - b - bin in W+1 bits.
module serial_sub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] res;
  assign res  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign d    = res[W-1:0];
  // An underflow of the W+1-bit difference sets the top bit.
  assign bout = res[W];
endmodule

module serial_subtractor32 #(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            Bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] D,
  output logic            Bout
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic            V
`endif
);

  localparam int N  = BITS / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (BITS % CHUNK != 0) begin : g_bad_chunk
    $error("serial_subtractor32: BITS must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [BITS-1:0] a_q, b_q, d_q;
  logic            brw_q, bout_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q, out_valid_q;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic            v_q;
`endif

  // Current slice operands and the slice result feeding the next state.
  int              sel;
  logic [CHUNK-1:0] a_sl, b_sl, diff_d;
  logic            brw_d;

  assign sel  = int'(cnt_q) * CHUNK;
  assign a_sl = a_q[sel +: CHUNK];
  assign b_sl = b_q[sel +: CHUNK];

  serial_sub_slice #(.W(CHUNK)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (brw_q),
    .d    (diff_d),
    .bout (brw_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      brw_q       <= 1'b0;
      bout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      v_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            brw_q      <= Bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          d_q[sel +: CHUNK] <= diff_d;
          brw_q             <= brw_d;
          cnt_q             <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            bout_q      <= brw_d;
`ifdef SUB_OVERFLOW_FLAG_EN
            // diff_d holds the top slice here, so its MSB is D's sign bit.
            v_q         <= (a_q[BITS-1] != b_q[BITS-1]) &&
                           (diff_d[CHUNK-1] != a_q[BITS-1]);
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
`ifdef SUB_OVERFLOW_FLAG_EN
  assign V         = v_q;
`endif

endmodule
